// File: rtl/md_seq_pkg.sv
// Shared definitions for the md_seq RV32M multiply/divide sequencer:
// op encodings (func3), FSM states and special-case result constants.
package md_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  localparam logic [XLEN-1:0] MD_DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] MD_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/md_seq_if.sv
// EX-stage request/response bundle between the pipeline (master) and md_seq (slave).
interface md_seq_if;
  import md_seq_pkg::*;

  // md_req is a level request held while the MD op sits in EX; it is accepted
  // in IDLE when md_flush is low. md_stall = md_req & ~md_done. md_result and
  // md_wr_regindex are valid in the single md_done cycle. md_flush kills the op.
  logic              md_req;
  logic [2:0]        md_op;
  logic [XLEN-1:0]   md_rs1v;
  logic [XLEN-1:0]   md_rs2v;
  logic [4:0]        md_rd;
  logic              md_flush;
  logic              md_stall;
  logic              md_done;
  logic [XLEN-1:0]   md_result;
  logic [4:0]        md_wr_regindex;
  logic              md_busy;
  md_state_e         md_dbg_state;

  modport master (
    output md_req, md_op, md_rs1v, md_rs2v, md_rd, md_flush,
    input  md_stall, md_done, md_result, md_wr_regindex, md_busy, md_dbg_state
  );

  modport slave (
    input  md_req, md_op, md_rs1v, md_rs2v, md_rd, md_flush,
    output md_stall, md_done, md_result, md_wr_regindex, md_busy, md_dbg_state
  );

endinterface

// File: rtl/md_iter_step.sv
// One iteration of the shared 33-bit add/sub + shift datapath: a shift-add
// multiply step (div_i=0) or a restoring divide step (div_i=1).
module md_iter_step
  import md_seq_pkg::*;
(
  input  logic              div_i,
  input  logic [2*XLEN:0]   acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN:0]   acc_o,
  output logic              qbit_o
);

  logic [XLEN:0]   a;
  logic [XLEN:0]   b;
  logic            cin;
  logic [XLEN+1:0] sum;

  // Multiply: acc = {hi[32:0], multiplier[31:0]}, add then shift right.
  // Divide:   acc = {rem[32:0], dividend/quotient[31:0]}, shift left then trial-subtract.
  always_comb begin
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    acc_o  = acc_i;
    qbit_o = 1'b0;
    if (div_i) begin
      a   = acc_i[2*XLEN-1:XLEN-1];
      b   = ~{1'b0, opnd_i};
      cin = 1'b1;
    end else begin
      a = acc_i[2*XLEN:XLEN];
      b = acc_i[0] ? {1'b0, opnd_i} : '0;
    end
    sum = {1'b0, a} + {1'b0, b} + {{(XLEN+1){1'b0}}, cin};
    if (div_i) begin
      // Carry out of rem' + ~d + 1 means rem' >= d.
      qbit_o = sum[XLEN+1];
      acc_o  = {(qbit_o ? sum[XLEN:0] : a), acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o  = {1'b0, sum[XLEN:0], acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/md_seq.sv
// RV32M multiply/divide sequencer iterating md_iter_step 32 times per op.
// Define MD_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU in the accept cycle.
module md_seq
  import md_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  md_seq_if.slave  md
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  md_op_e            op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              s1, s2, div0, ovf, kill, fast_hit;
  logic [XLEN-1:0]   abs1, abs2, fast_res, fix_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [2*XLEN:0]   step_acc;
  logic              step_qbit;

  assign op_in = md_op_e'(md.md_op);
  // Effective operand signs: only the signed operands of signed ops count.
  assign s1    = md.md_rs1v[XLEN-1] & (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign s2    = md.md_rs2v[XLEN-1] & (op_in inside {MD_MULH, MD_DIV, MD_REM});
  assign abs1  = s1 ? -md.md_rs1v : md.md_rs1v;
  assign abs2  = s2 ? -md.md_rs2v : md.md_rs2v;
  assign div0  = md.md_op[2] & (md.md_rs2v == '0);
  assign ovf   = (op_in == MD_DIV || op_in == MD_REM) &&
                 md.md_rs1v == MD_OVF_Q && md.md_rs2v == MD_DIV0_Q;
  assign kill  = md.md_flush | (~md.md_req & (state_q == MD_CALC || state_q == MD_FIXUP));

`ifdef MD_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fm_a, fm_b, fm_p;
  assign fm_a     = {{XLEN{s1}}, md.md_rs1v};
  assign fm_b     = {{XLEN{s2}}, md.md_rs2v};
  assign fm_p     = fm_a * fm_b;
  assign fast_hit = ~md.md_op[2];
  assign fast_res = (op_in == MD_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  md_iter_step u_step (
    .div_i  (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .qbit_o (step_qbit)
  );

  assign prod = neg_res_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = quo;
    case (op_q)
      MD_MUL:                       fix_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MD_REM, MD_REMU:              fix_res = rem;
      default:                      fix_res = quo;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      MD_IDLE: begin
        if (md.md_req && !md.md_flush) begin
          op_d      = op_in;
          rd_d      = md.md_rd;
          neg_res_d = s1 ^ s2;
          neg_rem_d = s1;
          if (div0) begin
            result_d = op_in[1] ? md.md_rs1v : MD_DIV0_Q;
            state_d  = MD_DONE;
          end else if (ovf) begin
            result_d = op_in[1] ? '0 : MD_OVF_Q;
            state_d  = MD_DONE;
          end else if (fast_hit) begin
            result_d = fast_res;
            state_d  = MD_DONE;
          end else begin
            state_d = MD_CALC;
            cnt_d   = '0;
            acc_d   = {{(XLEN+1){1'b0}}, (md.md_op[2] ? abs1 : abs2)};
            opnd_d  = md.md_op[2] ? abs2 : abs1;
          end
        end
      end
      MD_CALC: begin
        acc_d = {step_acc[2*XLEN:1], step_acc[0] | step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = MD_FIXUP;
      end
      MD_FIXUP: begin
        result_d = fix_res;
        state_d  = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    // A killed op returns to IDLE and never touches the visible result.
    if (kill) begin
      state_d  = MD_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= MD_MUL;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign md.md_done        = (state_q == MD_DONE) & ~md.md_flush;
  assign md.md_stall       = md.md_req & ~md.md_done;
  assign md.md_busy        = (state_q != MD_IDLE);
  assign md.md_result      = result_q;
  assign md.md_wr_regindex = rd_q;
  assign md.md_dbg_state   = state_q;

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: directed and random RV32M ops compared every
// cycle against an arithmetic reference model with a latency countdown.
module tb_md_seq;
  import md_seq_pkg::*;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  md_seq_if md();

  md_seq dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MD_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 34;
  endfunction

  // m_remain counts cycles left until the done cycle (0 = done cycle).
  bit          m_active = 1'b0;
  int          m_remain = 0;
  logic [31:0] m_pend   = '0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_rd     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_remain <= 0;
      m_result <= '0;
      m_rd     <= '0;
    end else if (m_active) begin
      if (m_remain == 0)                   m_active <= 1'b0;
      else if (md.md_flush || !md.md_req)  m_active <= 1'b0;
      else if (m_remain == 1) begin
        m_remain <= 0;
        m_result <= m_pend;
      end else                             m_remain <= m_remain - 1;
    end else if (md.md_req && !md.md_flush) begin
      m_active <= 1'b1;
      m_rd     <= md.md_rd;
      m_pend   <= ref_md(md.md_op, md.md_rs1v, md.md_rs2v);
      m_remain <= lat_of(md.md_op, md.md_rs1v, md.md_rs2v) - 1;
      if (lat_of(md.md_op, md.md_rs1v, md.md_rs2v) == 1)
        m_result <= ref_md(md.md_op, md.md_rs1v, md.md_rs2v);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("done",   md.md_done, m_active && m_remain == 0 && !md.md_flush);
    chk("stall",  md.md_stall, md.md_req && !(m_active && m_remain == 0 && !md.md_flush));
    chk("busy",   md.md_busy, m_active);
    chk("result", md.md_result, m_result);
    chk("regidx", md.md_wr_regindex, m_rd);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit lit, input logic [31:0] exp_res,
                        input int exp_lat);
    int k;
    bit seen;
    @(posedge clk); #1;
    md.md_req = 1'b1; md.md_flush = 1'b0;
    md.md_op = op; md.md_rs1v = a; md.md_rs2v = b; md.md_rd = rd;
    k = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (md.md_done) seen = 1'b1;
      else begin
        k++;
        @(posedge clk); #1;
        // operands after accept must be ignored
        md.md_op = 3'($urandom_range(0, 7));
        md.md_rs1v = $urandom(); md.md_rs2v = $urandom();
        md.md_rd = 5'($urandom_range(0, 31));
      end
    end
    if (!seen) begin
      errors++; vectors++;
      $display("FAIL timeout op %0d: no md_done after %0d cycles, required %0d", op, k, exp_lat);
    end else begin
      chk("latency", k, exp_lat);
      if (lit) begin
        chk("lit_result", md.md_result, exp_res);
        chk("lit_regidx", md.md_wr_regindex, rd);
      end
    end
  endtask

  task automatic abort_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int n, input bit use_flush);
    @(posedge clk); #1;
    md.md_req = 1'b1; md.md_flush = 1'b0;
    md.md_op = op; md.md_rs1v = a; md.md_rs2v = b; md.md_rd = rd;
    @(posedge clk);
    repeat (n) @(posedge clk);
    #1;
    if (use_flush) md.md_flush = 1'b1;
    else           md.md_req = 1'b0;
    @(posedge clk); #1;
    md.md_flush = 1'b0; md.md_req = 1'b0;
    chk("abort_busy", md.md_busy, 1'b0);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    md.md_req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  localparam int LM = lat_of(3'd0, 32'd1, 32'd1);

  initial begin
    rst = 1'b1;
    md.md_req = 1'b0; md.md_flush = 1'b0; md.md_op = '0;
    md.md_rs1v = '0; md.md_rs2v = '0; md.md_rd = '0;
    @(posedge clk); #1;
    chk("rst_busy", md.md_busy, 1'b0);
    chk("rst_result", md.md_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'd0, 32'd3, 32'hFFFF_FFFB, 5'd5, 1, 32'hFFFF_FFF1, LM);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1, 32'h4000_0000, LM);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, 1, 32'h4000_0000, LM);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 1, 32'hFFFF_FFFF, LM);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd9, 1, 32'hFFFF_FFFD, 34);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd10, 1, 32'd1, 34);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 1, 32'd14, 34);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 1, 32'd2, 34);
    idle(2);
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 1, 32'hFFFF_FFFF, 1);
    run_op(3'd7, 32'd5, 32'd0, 5'd14, 1, 32'd5, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'd0, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h8000_0000, 1);

    // flush in CALC counter 10: result must stay at the last DIV overflow value
    abort_op(3'd4, 32'd1000, 32'd7, 5'd17, 10, 1'b1);
    chk("flush_keep", md.md_result, 32'h8000_0000);
    run_op(3'd5, 32'd100, 32'd7, 5'd18, 1, 32'd14, 34);

    // asynchronous reset in CALC counter 5
    @(posedge clk); #1;
    md.md_req = 1'b1; md.md_op = 3'd5; md.md_rs1v = 32'd77; md.md_rs2v = 32'd5; md.md_rd = 5'd19;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1; md.md_req = 1'b0;
    #1;
    chk("arst_busy", md.md_busy, 1'b0);
    chk("arst_done", md.md_done, 1'b0);
    chk("arst_stall", md.md_stall, 1'b0);
    chk("arst_result", md.md_result, 32'd0);
    chk("arst_regidx", md.md_wr_regindex, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'd0, 32'd6, 32'd7, 5'd20, 1, 32'd42, LM);

    for (int i = 0; i < 50; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      if ($urandom_range(0, 7) == 0) begin
`ifdef MD_FAST_MUL_EN
        op = 3'(4 + $urandom_range(0, 3));
`else
        op = 3'($urandom_range(0, 7));
`endif
        abort_op(op, $urandom(), 32'($urandom_range(1, 1000)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 32), 1'($urandom_range(0, 1)));
      end else begin
        op = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
        run_op(op, a, b, 5'($urandom_range(0, 31)), 0, 32'd0, lat_of(op, a, b));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer in the EX stage.
- Accepts an operation when decode flags de2ex_MD_OP, and runs an iterative shift-add or restoring-divide datapath.
- Holds the pipeline with a stall output until the result is ready, then hands the result and destination index to writeback.
- Has one requester. The FSM sequences a single shared 33-bit add/sub + shift datapath for both mul and div.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- md_req  in  1  level request; high while the MD instruction sits in EX
- md_op  in  3  func3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU)
- md_rs1v  in  32  operand 1
- md_rs2v  in  32  operand 2
- md_rd  in  5  destination register index
- md_flush  in  1  kill in-flight op (branch_predict_err / trap)
- md_stall  out  1  md_req & ~md_done (combinational)
- md_done  out  1  one-cycle pulse, result valid
- md_result  out  32  result, registered, held until next accept
- md_wr_regindex  out  5  captured md_rd, valid with md_done
- md_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset forces IDLE, counter 0, and all outputs 0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - Accept when md_req & ~md_flush.
  - On accept, capture the operands, the op, md_rd, and the sign flags. Operands are converted to absolute values for signed ops: MULH both signed, MULHSU rs1 only, DIV/REM both signed.
  - Divide-by-zero (rs2=0, ops 4-7) goes straight to DONE:
    - quotient = 0xFFFFFFFF
    - remainder = rs1
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) goes straight to DONE:
    - DIV = 0x80000000
    - REM = 0
  - All other accepts go to CALC with the counter cleared.
- CALC: one iteration per cycle, exactly 32 cycles (counter 0..31).
  - Multiply: shift-add into a 64-bit product accumulator.
  - Divide: restoring step into a 33-bit partial remainder, producing quotient bits.
  - When the counter reaches 31, go to FIXUP.
- FIXUP (1 cycle):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ (DIV).
  - Negate the remainder if the dividend was negative (REM).
  - Select the result: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register md_result, then go to DONE.
- DONE: md_done=1 for exactly one cycle; next state is IDLE.
- Latency from the accept edge:
  - Normal op: md_done in cycle 34 (1 accept + 32 CALC + 1 FIXUP).
  - Special-case op: md_done in cycle 1.
- Back-to-back: the cycle after DONE is IDLE and can accept a new md_req at once.
- md_flush:
  - In any state, the next state is IDLE with no md_done.
  - md_result keeps its old value.
  - Flush takes priority over accept in the same cycle.
- md_req falling in CALC/FIXUP without flush is treated as a flush.
- md_req is ignored in DONE.
- Input stability: md_op and the operands are sampled only at accept; later changes are ignored.
- Widths: all arithmetic is modulo 2^32 except the 64-bit product and the 33-bit remainder; no X propagation out of reset.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- When defined:
  - Ops 0-3 compute in the accept cycle using a 33x33 signed multiplier with sign-extended operands.
  - The FSM goes IDLE to DONE, so md_done comes in cycle 1.
  - Divide is unchanged.
- When undefined: multiply uses the 34-cycle iterative path, and no hardware multiplier is inferred.

Decomposition:
- Shared package / define file:
  - MD_MUL..MD_REMU op encodings matching func3.
  - MD_IDLE/MD_CALC/MD_FIXUP/MD_DONE state encodings.
  - MD_DIV0_Q constant (0xFFFFFFFF) and MD_OVF_Q constant (0x80000000).
- One sub-module, md_iter_step: a combinational single-iteration step.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator and quotient bit.
  - Instantiated once; md_seq holds the FSM, counter and registers.

Test Plan:
- MUL 3 x 0xFFFFFFFB (-5), with md_req held → md_stall high for cycles 0-33, md_done in cycle 34, md_result = 0xFFFFFFF1, md_wr_regindex = md_rd.
- MULH 0x80000000 x 0x80000000 → 0x40000000; MULHU of the same operands → 0x40000000; MULHSU 0xFFFFFFFF x 2 → 0xFFFFFFFF.
- DIV 7 / 0xFFFFFFFE (-2) → 0xFFFFFFFD; REM of the same operands → 1; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → md_done in cycle 1, result 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, md_done in cycle 1.
- Accept DIV, assert md_flush in CALC cycle 10 → IDLE next cycle, no md_done, md_result unchanged. Apply a new req the following cycle → completes normally.
- Assert rst in CALC cycle 5 → all outputs 0 immediately. With MD_FAST_MUL_EN defined, MUL 6x7 → md_done in cycle 1, result 42.
